sht_crc_check: RTL and testbench

SHT_CRC_CHECK -- requirements
Module: sht_crc_check

---
 rtl/sht_crc_check.sv | 137 +++++++++++++
 tb/tb_sht_crc_check.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sht_crc_check.sv
// Frame checker for 3-byte sensor transfers (command, data MSB, data LSB) plus a CRC-8 checksum byte.
// Optional build macro CRC_SEED_STATUS_EN adds a status_reg input that supplies the CRC seed.
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | no frame open, waiting for start
// WAIT_BYTE | byte_ready high, waiting for the next byte
// SHIFT     | one bit per cycle into the CRC, 8 cycles per byte
// CHECK     | compare bit-reversed CRC with the received checksum
module sht_crc_check (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
`ifdef CRC_SEED_STATUS_EN
  input  logic [7:0] status_reg,
`endif
  output logic       byte_ready,
  output logic       crc_done,
  output logic       crc_ok,
  output logic [7:0] crc_value,
  output logic [7:0] crc_err_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, CHECK} state_t;

  state_t     state, state_n;
  logic [7:0] crc;
  logic [7:0] crc_next;
  logic [7:0] crc_rev;
  logic [7:0] shreg;
  logic [7:0] rx_sum;
  logic [7:0] seed;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic       accept;
  logic       fb;
  logic       match;

`ifdef CRC_SEED_STATUS_EN
  // Only the low nibble of the status register feeds the seed, reversed into the top nibble.
  assign seed = {status_reg[0], status_reg[1], status_reg[2], status_reg[3], 4'b0000};
  logic unused_status;
  assign unused_status = ^status_reg[7:4];
`else
  assign seed = 8'h00;
`endif

  // start has priority: a byte offered in the same cycle is not consumed.
  assign accept   = byte_valid && byte_ready && !start;
  assign fb       = crc[7] ^ shreg[7];
  assign crc_next = {crc[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
  assign match    = (crc_rev == rx_sum);

  always_comb begin
    crc_rev = 8'h00;
    for (int i = 0; i < 8; i++) begin
      crc_rev[i] = crc[7-i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = WAIT_BYTE;
    end else begin
      case (state)
        IDLE:      state_n = IDLE;
        WAIT_BYTE: if (accept) state_n = (byte_cnt == 2'd3) ? CHECK : SHIFT;
        SHIFT:     if (bit_cnt == 3'd0) state_n = WAIT_BYTE;
        CHECK:     state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ready = (state == WAIT_BYTE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      crc         <= 8'h00;
      shreg       <= 8'h00;
      rx_sum      <= 8'h00;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 2'd0;
      crc_done    <= 1'b0;
      crc_ok      <= 1'b0;
      crc_value   <= 8'h00;
      crc_err_cnt <= 8'h00;
    end else begin
      crc_done <= 1'b0;
      if (start) begin
        crc      <= seed;
        byte_cnt <= 2'd0;
        bit_cnt  <= 3'd0;
      end else begin
        case (state)
          WAIT_BYTE: begin
            if (accept) begin
              if (byte_cnt == 2'd3) begin
                rx_sum <= byte_in;
              end else begin
                shreg   <= byte_in;
                bit_cnt <= 3'd7;
              end
            end
          end
          SHIFT: begin
            crc     <= crc_next;
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) byte_cnt <= byte_cnt + 2'd1;
          end
          CHECK: begin
            crc_done  <= 1'b1;
            crc_ok    <= match;
            crc_value <= crc_rev;
            if (!match && crc_err_cnt != 8'hFF) crc_err_cnt <= crc_err_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sht_crc_check.sv
// Scoreboard bench for sht_crc_check: expected results are queued at frame issue and checked on crc_done.
module tb_sht_crc_check;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       crc_done;
  logic       crc_ok;
  logic [7:0] crc_value;
  logic [7:0] crc_err_cnt;
`ifdef CRC_SEED_STATUS_EN
  logic [7:0] status_reg = 8'h00;
`endif

  typedef struct packed {
    logic       ok;
    logic [7:0] val;
    logic [7:0] err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_err = 0;

  sht_crc_check dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
`ifdef CRC_SEED_STATUS_EN
    .status_reg  (status_reg),
`endif
    .byte_ready  (byte_ready),
    .crc_done    (crc_done),
    .crc_ok      (crc_ok),
    .crc_value   (crc_value),
    .crc_err_cnt (crc_err_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every crc_done must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && crc_done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got crc_done=1 expected no pulse");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("crc_ok",      {7'd0, crc_ok}, {7'd0, e.ok});
        check("crc_value",   crc_value,      e.val);
        check("crc_err_cnt", crc_err_cnt,    e.err);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clock);
    while (!byte_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!byte_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got byte_ready=0 expected 1 within 40 cycles");
    end
    @(posedge clock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] cs, input logic [7:0] val);
    exp_t e;
    e.ok = (cs == val);
    if (!e.ok && exp_err < 255) exp_err++;
    e.err = 8'(exp_err);
    e.val = val;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL done_timeout: got %0d pending results expected 0", q.size());
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] cs, input logic [7:0] val);
    push_exp(cs, val);
    pulse_start();
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(cs);
    wait_drain();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ready",   {7'd0, byte_ready}, 8'h00);
    check("rst_done",    {7'd0, crc_done},   8'h00);
    check("rst_ok",      {7'd0, crc_ok},     8'h00);
    check("rst_value",   crc_value,          8'h00);
    check("rst_err_cnt", crc_err_cnt,        8'h00);
    @(posedge clock); #1;

    // Known-good frame, its corrupted-checksum twin, and two further hand-computed vectors.
    frame(8'h05, 8'h00, 8'h31, 8'hD9, 8'hD9);
    frame(8'h05, 8'h00, 8'h31, 8'hD8, 8'hD9);
    frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    frame(8'h00, 8'h00, 8'h01, 8'h8C, 8'h8C);

    // Results hold across a new start.
    pulse_start();
    @(negedge clock);
    check("hold_ok",    {7'd0, crc_ok}, 8'h01);
    check("hold_value", crc_value,      8'h8C);
    check("hold_ready", {7'd0, byte_ready}, 8'h01);
    @(posedge clock); #1;

    // Ready gap: held byte_valid during SHIFT must not be consumed.
    push_exp(8'hD9, 8'hD9);
    pulse_start();
    byte_in = 8'h05; byte_valid = 1'b1;
    @(negedge clock);
    check("gap_ready_n", {7'd0, byte_ready}, 8'h01);
    @(posedge clock); #1;
    byte_in = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      check($sformatf("gap_low_%0d", i), {7'd0, byte_ready}, 8'h00);
    end
    @(negedge clock);
    check("gap_ready_n9", {7'd0, byte_ready}, 8'h01);
    @(posedge clock); #1;
    byte_valid = 1'b0;
    send_byte(8'h31);
    send_byte(8'hD9);
    wait_drain();

    // Restart after two bytes: only the second frame reports.
    pulse_start();
    send_byte(8'h05);
    send_byte(8'h00);
    frame(8'h05, 8'h00, 8'h31, 8'hD9, 8'hD9);

    // start together with byte_valid: start wins, byte not consumed.
    push_exp(8'hD9, 8'hD9);
    pulse_start();
    start = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA;
    @(posedge clock); #1;
    start = 1'b0; byte_valid = 1'b0;
    @(negedge clock);
    check("start_wins_ready", {7'd0, byte_ready}, 8'h01);
    @(posedge clock); #1;
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h31);
    send_byte(8'hD9);
    wait_drain();

    // Saturation of the error counter.
    for (int i = 0; i < 256; i++) begin
      frame(8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
    end
    @(negedge clock);
    check("err_saturated", crc_err_cnt, 8'hFF);
    @(posedge clock); #1;

    // Reset mid-frame discards it and clears everything.
    pulse_start();
    send_byte(8'h05);
    send_byte(8'h00);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("mid_rst_ready", {7'd0, byte_ready}, 8'h00);
    check("mid_rst_ok",    {7'd0, crc_ok},     8'h00);
    check("mid_rst_value", crc_value,          8'h00);
    check("mid_rst_err",   crc_err_cnt,        8'h00);
    repeat (20) @(posedge clock);
    #1;
    check("queue_empty", 8'(q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
